// File: rtl/syn_dual_p_ram.sv
// Simple dual-port synchronous RAM: byte-enabled write port A, read port B,
// selectable read latency, read-during-write policy and post-reset zero-fill.
module syn_dual_p_ram #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 16,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  addr_err,
  output logic                  init_done
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_L  = (ADDR_W + 1)'(DEPTH - 1);

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("syn_dual_p_ram: RD_LAT must be 1 or 2");
  end
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("syn_dual_p_ram: DATA_W must be a multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("syn_dual_p_ram: DEPTH must be in 1..2**ADDR_W");
  end

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   init_cnt_r;
  logic                init_last_s;
  logic                init_wr_s;
  logic                run_s;
  logic                init_done_r;

  logic                wr_in_rng_s;
  logic                rd_in_rng_s;
  logic                wr_acc_s;
  logic                rd_acc_s;
  logic                err_s;
  logic [DATA_W-1:0]   mem_rd_s;
  logic [DATA_W-1:0]   rd_word_s;

  logic [DATA_W-1:0]   rd1_data_r;
  logic                rd1_valid_r;
  logic                addr_err_r;

  assign init_last_s = ({1'b0, init_cnt_r} == LAST_L);

  // Init FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Init FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_last_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // Init FSM outputs
  always_comb begin
    init_wr_s = 1'b0;
    run_s     = 1'b0;
    case (state_r)
      ST_INIT: init_wr_s = 1'b1;
      ST_RUN:  run_s     = 1'b1;
      default: begin
        init_wr_s = 1'b0;
        run_s     = 1'b0;
      end
    endcase
  end

  // Zero-fill address counter; restarts from word 0 on every reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt_r <= '0;
    end else if (init_wr_s && !init_last_s) begin
      init_cnt_r <= init_cnt_r + ADDR_W'(1);
    end else begin
      init_cnt_r <= init_cnt_r;
    end
  end

  // init_done rises on the same edge the FSM enters RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done_r <= 1'b0;
    end else begin
      init_done_r <= (state_nxt_s == ST_RUN);
    end
  end

  // Access qualification, range check and read-during-write data selection
  always_comb begin
    wr_in_rng_s = ({1'b0, wr_addr} < DEPTH_L);
    rd_in_rng_s = ({1'b0, rd_addr} < DEPTH_L);
    wr_acc_s    = run_s & cs & wr_en & wr_in_rng_s;
    rd_acc_s    = run_s & cs & rd_en & rd_in_rng_s;
    err_s       = run_s & cs & ((wr_en & ~wr_in_rng_s) | (rd_en & ~rd_in_rng_s));
    mem_rd_s    = mem_r[rd_addr];
    if (!rd_acc_s) begin
      rd_word_s = '0;
    end else if ((RDW_MODE == 1) && wr_acc_s && (wr_addr == rd_addr)) begin
      rd_word_s = merge_bytes(mem_rd_s, wr_data, wr_be);
    end else begin
      rd_word_s = mem_rd_s;
    end
  end

  // Storage array: zero-fill during init, byte-lane writes in run
  always_ff @(posedge clk) begin
    if (init_wr_s) begin
      mem_r[init_cnt_r] <= '0;
    end else if (wr_acc_s) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) begin
          mem_r[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // First read stage and address-error pulse; idle cycles load zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_data_r  <= '0;
      rd1_valid_r <= 1'b0;
      addr_err_r  <= 1'b0;
    end else begin
      rd1_data_r  <= rd_word_s;
      rd1_valid_r <= rd_acc_s;
      addr_err_r  <= err_s;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] rd2_data_r;
    logic              rd2_valid_r;

    // Extra output register stage for the two-cycle latency build
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd2_data_r  <= '0;
        rd2_valid_r <= 1'b0;
      end else begin
        rd2_data_r  <= rd1_data_r;
        rd2_valid_r <= rd1_valid_r;
      end
    end

    assign rd_data  = rd2_data_r;
    assign rd_valid = rd2_valid_r;
  end else begin : g_lat1
    assign rd_data  = rd1_data_r;
    assign rd_valid = rd1_valid_r;
  end

  assign addr_err  = addr_err_r;
  assign init_done = init_done_r;

endmodule

// File: doc/syn_dual_p_ram.md
Name: syn_dual_p_ram

Overview:
Parametrised simple dual-port synchronous RAM: one write port (A) and one independent read port (B) in a single clock domain. It adds per-byte write enables, a selectable 1- or 2-cycle read latency, a configurable read-during-write policy and a post-reset zero-fill sequencer. It is the drop-in successor to the 16x8 single-port RAM for buffers that need simultaneous read and write.

Parameters:
DATA_W, 8, data width in bits; must be a multiple of 8
ADDR_W, 4, address width in bits
DEPTH, 16, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
RD_LAT, 1, read latency in cycles; legal values are 1 or 2
RDW_MODE, 0, same-address read-during-write policy: 0 = read-first (returns old data), 1 = write-first (returns new data)

Ports:
clk  input  1  clock; all logic is on the rising edge
rst_n  input  1  asynchronous active-low reset
cs  input  1  chip select; gates both ports
wr_en  input  1  write request, port A
wr_addr  input  ADDR_W  write address
wr_be  input  DATA_W/8  byte enables; bit i enables data bits 8i+7:8i
wr_data  input  DATA_W  write data
rd_en  input  1  read request, port B
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  read data
rd_valid  output  1  rd_data holds the result of a read
addr_err  output  1  one-cycle pulse reporting an out-of-range access
init_done  output  1  zero-fill sequence is complete and the RAM accepts accesses

Behaviour:
- Reset (asynchronous, rst_n=0): rd_data=0, rd_valid=0, addr_err=0, init_done=0, and the pipeline registers are cleared. Memory contents are not reset directly.
- Init FSM has two states: INIT and RUN.
  - INIT: an internal counter runs from 0 to DEPTH-1 and writes 0 to one word per cycle. On the cycle that writes word DEPTH-1 the FSM moves to RUN. init_done goes high on the following edge, DEPTH cycles after rst_n deasserts.
  - All wr_en and rd_en requests in INIT are ignored: no write occurs, rd_valid=0, addr_err=0.
  - If reset asserts mid-init, the sequence restarts from word 0.
- Write (RUN): when cs=1, wr_en=1 and wr_addr<DEPTH, each byte lane whose wr_be bit is 1 is written on the edge. Lanes with a 0 enable keep their contents. wr_be=0 is a legal no-op.
- Read (RUN), RD_LAT=1: when cs=1, rd_en=1 and rd_addr<DEPTH, rd_data is updated with mem[rd_addr] on the next edge and rd_valid=1.
- Read, RD_LAT=2: an extra output register stage is added; data and rd_valid appear one cycle later. Back-to-back reads give one result per cycle.
- Idle cycle (cs=0, or rd_en=0): at the final output stage rd_data=0 and rd_valid=0 in the corresponding cycle. This preserves the zero-on-idle output of the previous RAM.
- Read-during-write to the same address on the same edge:
  - RDW_MODE=0: the old word is returned.
  - RDW_MODE=1: the merged word is returned, i.e. new bytes in enabled lanes and old bytes elsewhere.
  - Different addresses do not interact.
- Out of range (address >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - The write is dropped and the read returns 0 with rd_valid=0.
  - addr_err pulses high for one cycle, aligned with the edge after the request, independent of RD_LAT.
  - A read and a write that are both out of range in the same cycle produce a single pulse.
- cs=0 suppresses both ports and addr_err.
- Memory is inferred as a register array with no vendor primitives. Synthesis must reject RD_LAT outside {1,2} or DATA_W%8 != 0.

Test Plan:
- Init: release rst_n with DEPTH=16 -> init_done rises exactly 16 cycles later. A read of every address then returns 0x00 with rd_valid=1.
- Byte enables: DATA_W=32, write 0xAABBCCDD at address 3 with wr_be=4'b1111, then write 0x11223344 with wr_be=4'b0101 -> a read of address 3 returns 0xAA22CC44.
- Read-during-write: address 5 holds 0x12; write 0x34 to address 5 while reading address 5 -> RDW_MODE=0 returns 0x12 and RDW_MODE=1 returns 0x34. A second read returns 0x34 in both modes.
- Latency and idle: RD_LAT=2, read addresses 0,1,2 back-to-back, then rd_en=0 -> data appears on cycles +2,+3,+4 with rd_valid=1, then rd_data=0x00 and rd_valid=0. Holding cs=0 with rd_en=1 gives rd_data=0.
- Range and reset: DEPTH=12, write to address 13 then read address 13 -> memory unchanged, rd_valid=0, one addr_err pulse each. Assert rst_n at init count 7 -> the zero-fill restarts and init_done rises 12 cycles after release.
